// File: rtl/mavg_channel_scheduler_if.sv
// Request/result bundle between the sample front end and the shared moving-average engine.
// The master side raises requests and flushes; the slave side returns acknowledged results.
interface mavg_channel_scheduler_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 2,
  parameter int SUM_W  = 4
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*DATA_W-1:0] sample_in;
  logic                     flush;
  logic [NUM_CH-1:0]        ack;
  logic                     res_valid;
  logic [1:0]               res_ch;
  logic [SUM_W-1:0]         res_sum;
  logic [DATA_W-1:0]        res_avg;
  logic                     res_full;
  logic                     busy;

  modport master (
    output req, sample_in, flush,
    input  ack, res_valid, res_ch, res_sum, res_avg, res_full, busy
  );

  modport slave (
    input  req, sample_in, flush,
    output ack, res_valid, res_ch, res_sum, res_avg, res_full, busy
  );
endinterface

// File: rtl/mavg_channel_scheduler.sv
// Round-robin scheduler sharing one moving-average update path between NUM_CH channels.
// Each grant runs IDLE -> CALC -> RESP; the result and one-hot ack appear in RESP.
module mavg_channel_scheduler #(
  parameter int NUM_CH      = 3,
  parameter int WINDOW_SIZE = 4,
  parameter int DATA_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mavg_channel_scheduler_if.slave  bus
);
  localparam int LOG2   = $clog2(WINDOW_SIZE);
  localparam int SUM_W  = DATA_W + LOG2;
  localparam int FILL_W = $clog2(WINDOW_SIZE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_RESP} state_t;

  state_t              state_q;
  logic [1:0]          rr_q;
  logic [1:0]          hold_ch_q;
  logic [DATA_W-1:0]   hold_sample_q;
  logic                flush_pend_q;
  logic [NUM_CH-1:0]   ack_q;
  logic                res_valid_q;
  logic [1:0]          res_ch_q;
  logic [SUM_W-1:0]    res_sum_q;
  logic [DATA_W-1:0]   res_avg_q;
  logic                res_full_q;

  logic [DATA_W-1:0]   win_q  [NUM_CH][WINDOW_SIZE];
  logic [SUM_W-1:0]    sum_q  [NUM_CH];
  logic [FILL_W-1:0]   fill_q [NUM_CH];

  logic                clear_all;
  logic                grant_found;
  logic [1:0]          grant_ch;
  int                  idx;
  logic [SUM_W-1:0]    sum_d;
  logic [FILL_W-1:0]   fill_d;

  // A pending or same-cycle flush takes the IDLE cycle; no grant is made then.
  assign clear_all = (state_q == ST_IDLE) && (flush_pend_q || bus.flush);

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!grant_found && bus.req[idx]) begin
        grant_found = 1'b1;
        grant_ch    = 2'(idx);
      end
    end
  end

  // Oldest slot is part of the sum, so subtracting it first can never underflow.
  always_comb begin
    sum_d  = sum_q[hold_ch_q] - SUM_W'(win_q[hold_ch_q][0]) + SUM_W'(hold_sample_q);
    fill_d = (fill_q[hold_ch_q] == FILL_W'(WINDOW_SIZE)) ? fill_q[hold_ch_q]
                                                          : fill_q[hold_ch_q] + FILL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < WINDOW_SIZE; s++) win_q[c][s] <= '0;
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else if (clear_all) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < WINDOW_SIZE; s++) win_q[c][s] <= '0;
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else if (state_q == ST_CALC) begin
      for (int s = 0; s < WINDOW_SIZE - 1; s++) win_q[hold_ch_q][s] <= win_q[hold_ch_q][s+1];
      win_q[hold_ch_q][WINDOW_SIZE-1] <= hold_sample_q;
      sum_q[hold_ch_q]  <= sum_d;
      fill_q[hold_ch_q] <= fill_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      hold_ch_q     <= '0;
      hold_sample_q <= '0;
      flush_pend_q  <= 1'b0;
      ack_q         <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_sum_q     <= '0;
      res_avg_q     <= '0;
      res_full_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q       <= '0;
          res_valid_q <= 1'b0;
          if (flush_pend_q || bus.flush) begin
            flush_pend_q <= 1'b0;
          end else if (grant_found) begin
            hold_ch_q     <= grant_ch;
            hold_sample_q <= bus.sample_in[grant_ch*DATA_W +: DATA_W];
            state_q       <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          res_sum_q   <= sum_d;
          res_avg_q   <= sum_d[SUM_W-1:LOG2];
          res_full_q  <= (fill_d == FILL_W'(WINDOW_SIZE));
          res_ch_q    <= hold_ch_q;
          ack_q       <= NUM_CH'(1) << hold_ch_q;
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          ack_q       <= '0;
          res_valid_q <= 1'b0;
          rr_q        <= (hold_ch_q == 2'(NUM_CH - 1)) ? 2'd0 : hold_ch_q + 2'd1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_avg   = res_avg_q;
  assign bus.res_full  = res_full_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule
